cache_ctrl: RTL and testbench

Per-request control FSM for the set-associative tag store built from `CHANNEL_COUNT` channel modules sharing one index. It accepts CPU lookups and evaluates every channel's hit, valid, LRU and modified outputs. It chooses a victim on a miss and runs write-back and fill handshakes with the memory side. It then drives the channels' write, modify, age and LRU-clear strobes so that the per-set LRU values stay a permutation of 0..`CHANNEL_COUNT`-1.

---
 rtl/cache_pkg.sv | 43 ++++
 rtl/cache_ctrl_victim_sel.sv | 50 +++++
 rtl/cache_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_cache_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// ============================================================================
//  Module      : cache_pkg
//  Description : Shared types, default widths and packed-bus field helper
//                for the set-associative tag store controller.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package cache_pkg;

    // Default geometry of the tag store
    localparam int unsigned TAG_WIDTH_DEF   = 8;
    localparam int unsigned INDEX_WIDTH_DEF = 4;
    localparam int unsigned LRU_WIDTH_DEF   = 3;
    localparam int unsigned CHANNEL_COUNT   = 4;

    // Widest packed per-channel bus the field helper accepts
    localparam int unsigned FIELD_BUS_W = 256;

    // Per-request controller states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_WB     = 3'd2,
        ST_FILL   = 3'd3,
        ST_UPDATE = 3'd4
    } state_t;

    // Extract field 'way' of 'width' bits from a packed per-channel bus.
    // Callers zero-extend their bus to FIELD_BUS_W and truncate the result.
    function automatic logic [31:0] get_field(
        input logic [FIELD_BUS_W-1:0] bus,
        input int unsigned            way,
        input int unsigned            width
    );
        logic [31:0] w_mask;
        w_mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return 32'(bus >> (way * width)) & w_mask;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cache_ctrl_victim_sel.sv
// ============================================================================
//  Module      : victim_sel
//  Description : Combinational miss-victim chooser. Prefers the lowest
//                invalid way; when every way is valid, takes the lowest way
//                holding the oldest LRU value (CHANNEL_COUNT-1).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module victim_sel
    import cache_pkg::*;
#(
    parameter int unsigned CHANNEL_COUNT = cache_pkg::CHANNEL_COUNT,
    parameter int unsigned LRU_WIDTH     = LRU_WIDTH_DEF,
    parameter int unsigned WAY_WIDTH     = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1
) (
    input  logic [CHANNEL_COUNT-1:0]           i_ch_valid,
    input  logic [CHANNEL_COUNT*LRU_WIDTH-1:0] i_ch_lru,
    output logic [WAY_WIDTH-1:0]               o_victim
);

    logic                 w_free_found;
    logic [WAY_WIDTH-1:0] w_free_way;
    logic                 w_old_found;
    logic [WAY_WIDTH-1:0] w_old_way;

    // Scan ways in ascending order so the lowest-numbered candidate wins
    always_comb begin
        w_free_found = 1'b0;
        w_free_way   = '0;
        w_old_found  = 1'b0;
        w_old_way    = '0;
        for (int w = 0; w < CHANNEL_COUNT; w++) begin
            if (!w_free_found && !i_ch_valid[w]) begin
                w_free_found = 1'b1;
                w_free_way   = WAY_WIDTH'(w);
            end
            if (!w_old_found &&
                (LRU_WIDTH'(get_field(FIELD_BUS_W'(i_ch_lru), unsigned'(w), LRU_WIDTH))
                 == LRU_WIDTH'(CHANNEL_COUNT - 1))) begin
                w_old_found = 1'b1;
                w_old_way   = WAY_WIDTH'(w);
            end
        end
        o_victim = w_free_found ? w_free_way : w_old_way;
    end

endmodule

`default_nettype wire

// File: rtl/cache_ctrl.sv
// ============================================================================
//  Module      : cache_ctrl
//  Description : Per-request control FSM for a set-associative tag store.
//                Looks up all ways, picks a victim on a miss, runs the
//                write-back / fill handshakes and keeps each set's LRU values
//                a permutation of 0..CHANNEL_COUNT-1.
//  Options     : CACHE_CTRL_STATS_EN adds saturating hit_cnt / miss_cnt.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module cache_ctrl
    import cache_pkg::*;
#(
    parameter int unsigned TAG_WIDTH     = TAG_WIDTH_DEF,
    parameter int unsigned INDEX_WIDTH   = INDEX_WIDTH_DEF,
    parameter int unsigned LRU_WIDTH     = LRU_WIDTH_DEF,
    parameter int unsigned CHANNEL_COUNT = cache_pkg::CHANNEL_COUNT
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    // CPU side
    input  logic                                 req_valid,
    output logic                                 req_ready,
    input  logic                                 req_we,
    input  logic [TAG_WIDTH+INDEX_WIDTH-1:0]     req_addr,
    output logic                                 resp_valid,
    output logic                                 resp_hit,
    // Channel side
    output logic [INDEX_WIDTH-1:0]               ch_index,
    output logic [TAG_WIDTH-1:0]                 ch_tag_in,
    input  logic [CHANNEL_COUNT-1:0]             ch_hit,
    input  logic [CHANNEL_COUNT-1:0]             ch_valid,
    input  logic [CHANNEL_COUNT-1:0]             ch_mod,
    input  logic [CHANNEL_COUNT*LRU_WIDTH-1:0]   ch_lru,
    input  logic [CHANNEL_COUNT*TAG_WIDTH-1:0]   ch_tag,
    output logic [CHANNEL_COUNT-1:0]             ch_wr,
    output logic [CHANNEL_COUNT-1:0]             ch_mod_in,
    output logic [CHANNEL_COUNT-1:0]             ch_age,
    output logic [CHANNEL_COUNT-1:0]             ch_lru_clr,
    // Memory side
    output logic                                 mem_req,
    output logic                                 mem_we,
    output logic [TAG_WIDTH+INDEX_WIDTH-1:0]     mem_addr,
    input  logic                                 mem_ack
`ifdef CACHE_CTRL_STATS_EN
    ,
    output logic [15:0]                          hit_cnt,
    output logic [15:0]                          miss_cnt
`endif
);

    localparam int unsigned ADDR_WIDTH = TAG_WIDTH + INDEX_WIDTH;
    localparam int unsigned WAY_WIDTH  = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1;

    state_t                   r_state;
    state_t                   w_next;
    logic [ADDR_WIDTH-1:0]    r_addr;
    logic                     r_we;
    logic [WAY_WIDTH-1:0]     r_target;
    logic                     r_hit;
    logic [TAG_WIDTH-1:0]     r_wb_tag;

    logic                     w_accept;
    logic                     w_hit_any;
    logic [WAY_WIDTH-1:0]     w_hit_way;
    logic [WAY_WIDTH-1:0]     w_victim;
    logic                     w_victim_dirty;
    logic [TAG_WIDTH-1:0]     w_victim_tag;
    logic [LRU_WIDTH-1:0]     w_target_lru;
    logic [CHANNEL_COUNT-1:0] w_age_mask;

    assign w_accept  = req_valid & req_ready;
    assign ch_index  = r_addr[INDEX_WIDTH-1:0];
    assign ch_tag_in = r_addr[ADDR_WIDTH-1:INDEX_WIDTH];

    victim_sel #(
        .CHANNEL_COUNT (CHANNEL_COUNT),
        .LRU_WIDTH     (LRU_WIDTH),
        .WAY_WIDTH     (WAY_WIDTH)
    ) u_victim_sel (
        .i_ch_valid (ch_valid),
        .i_ch_lru   (ch_lru),
        .o_victim   (w_victim)
    );

    assign w_victim_dirty = ch_valid[w_victim] & ch_mod[w_victim];
    assign w_victim_tag   = TAG_WIDTH'(get_field(FIELD_BUS_W'(ch_tag), 32'(w_victim), TAG_WIDTH));
    assign w_target_lru   = LRU_WIDTH'(get_field(FIELD_BUS_W'(ch_lru), 32'(r_target), LRU_WIDTH));

    // Lowest-numbered hitting way (multiple hits are illegal; lowest wins)
    always_comb begin
        w_hit_any = 1'b0;
        w_hit_way = '0;
        for (int w = CHANNEL_COUNT - 1; w >= 0; w--) begin
            if (ch_hit[w]) begin
                w_hit_any = 1'b1;
                w_hit_way = WAY_WIDTH'(w);
            end
        end
    end

    // Ways younger than the target age by one when the target becomes newest
    always_comb begin
        w_age_mask = '0;
        for (int w = 0; w < CHANNEL_COUNT; w++) begin
            if ((WAY_WIDTH'(w) != r_target) &&
                (LRU_WIDTH'(get_field(FIELD_BUS_W'(ch_lru), unsigned'(w), LRU_WIDTH)) < w_target_lru)) begin
                w_age_mask[w] = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Request context: address/write flag at acceptance, target and
    // write-back tag at lookup (held stable for the whole memory handshake)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr   <= '0;
            r_we     <= 1'b0;
            r_target <= '0;
            r_hit    <= 1'b0;
            r_wb_tag <= '0;
        end else begin
            if (w_accept) begin
                r_addr <= req_addr;
                r_we   <= req_we;
            end
            if (r_state == ST_LOOKUP) begin
                r_hit    <= w_hit_any;
                r_target <= w_hit_any ? w_hit_way : w_victim;
                r_wb_tag <= w_victim_tag;
            end
        end
    end

    // Next-state and all strobes; mod/wr stay low in UPDATE so the
    // channel's write priority cannot mask the LRU clear
    always_comb begin
        w_next     = r_state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_hit   = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        ch_wr      = '0;
        ch_mod_in  = '0;
        ch_age     = '0;
        ch_lru_clr = '0;
        case (r_state)
            ST_IDLE: begin
                req_ready = rst_n;
                if (req_valid) begin
                    w_next = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (w_hit_any) begin
                    ch_mod_in[w_hit_way] = r_we;
                    w_next               = ST_UPDATE;
                end else if (w_victim_dirty) begin
                    w_next = ST_WB;
                end else begin
                    w_next = ST_FILL;
                end
            end
            ST_WB: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = {r_wb_tag, r_addr[INDEX_WIDTH-1:0]};
                if (mem_ack) begin
                    w_next = ST_FILL;
                end
            end
            ST_FILL: begin
                mem_req  = 1'b1;
                mem_addr = r_addr;
                if (mem_ack) begin
                    ch_wr[r_target]     = 1'b1;
                    ch_mod_in[r_target] = r_we;
                    w_next              = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                ch_lru_clr[r_target] = 1'b1;
                ch_age               = w_age_mask;
                resp_valid           = 1'b1;
                resp_hit             = r_hit;
                w_next               = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

`ifdef CACHE_CTRL_STATS_EN
    logic [15:0] r_hit_cnt;
    logic [15:0] r_miss_cnt;

    // Saturating per-response hit/miss counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (r_state == ST_UPDATE) begin
            if (r_hit) begin
                if (r_hit_cnt != 16'hFFFF) r_hit_cnt <= r_hit_cnt + 16'd1;
            end else begin
                if (r_miss_cnt != 16'hFFFF) r_miss_cnt <= r_miss_cnt + 16'd1;
            end
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cache_ctrl.sv
// ============================================================================
//  Module      : tb_cache_ctrl
//  Description : Self-checking bench for cache_ctrl with a behavioural
//                 4-way channel array and a recency-queue cache model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_cache_ctrl;

    localparam int TW = 8, IW = 4, LW = 3, NW = 4, AW = 12, NSET = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              req_valid = 1'b0, req_we = 1'b0, mem_ack = 1'b0;
    logic [AW-1:0]     req_addr = '0;
    logic              req_ready, resp_valid, resp_hit, mem_req, mem_we;
    logic [AW-1:0]     mem_addr;
    logic [IW-1:0]     ch_index;
    logic [TW-1:0]     ch_tag_in;
    logic [NW-1:0]     ch_hit, ch_valid, ch_mod, ch_wr, ch_mod_in, ch_age, ch_lru_clr;
    logic [NW*LW-1:0]  ch_lru;
    logic [NW*TW-1:0]  ch_tag;
`ifdef CACHE_CTRL_STATS_EN
    logic [15:0]       hit_cnt, miss_cnt;
`endif

    cache_ctrl #(.TAG_WIDTH(TW), .INDEX_WIDTH(IW), .LRU_WIDTH(LW), .CHANNEL_COUNT(NW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_hit(resp_hit),
        .ch_index(ch_index), .ch_tag_in(ch_tag_in), .ch_hit(ch_hit), .ch_valid(ch_valid),
        .ch_mod(ch_mod), .ch_lru(ch_lru), .ch_tag(ch_tag), .ch_wr(ch_wr), .ch_mod_in(ch_mod_in),
        .ch_age(ch_age), .ch_lru_clr(ch_lru_clr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_ack(mem_ack)
`ifdef CACHE_CTRL_STATS_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    // ---------------- channel array (way w starts at LRU w) ----------------
    logic          m_valid [NSET][NW];
    logic [TW-1:0] m_tag   [NSET][NW];
    logic          m_mod   [NSET][NW];
    logic [LW-1:0] m_lru   [NSET][NW];

    initial begin
        for (int s = 0; s < NSET; s++)
            for (int w = 0; w < NW; w++) begin
                m_valid[s][w] = 1'b0; m_tag[s][w] = '0; m_mod[s][w] = 1'b0; m_lru[s][w] = LW'(w);
            end
    end

    always_comb begin
        for (int w = 0; w < NW; w++) begin
            ch_valid[w]        = m_valid[ch_index][w];
            ch_mod[w]          = m_mod[ch_index][w];
            ch_lru[w*LW +: LW] = m_lru[ch_index][w];
            ch_tag[w*TW +: TW] = m_tag[ch_index][w];
            ch_hit[w]          = m_valid[ch_index][w] && (m_tag[ch_index][w] == ch_tag_in);
        end
    end

    // Channel priority: write, then modify, then LRU clear, then age
    always @(posedge clk) begin
        for (int w = 0; w < NW; w++) begin
            if (ch_wr[w]) begin
                m_valid[ch_index][w] <= 1'b1;
                m_tag[ch_index][w]   <= ch_tag_in;
                m_mod[ch_index][w]   <= ch_mod_in[w];
            end else if (ch_mod_in[w]) m_mod[ch_index][w] <= 1'b1;
            else if (ch_lru_clr[w])    m_lru[ch_index][w] <= '0;
            else if (ch_age[w])        m_lru[ch_index][w] <= m_lru[ch_index][w] + LW'(1);
        end
    end

    // ---------------- reference model: recency queue per set ----------------
    bit            ref_valid [NSET][NW];
    bit            ref_dirty [NSET][NW];
    logic [TW-1:0] ref_tag   [NSET][NW];
    int            ref_ord   [NSET][$];   // most recent first

    initial begin
        for (int s = 0; s < NSET; s++)
            for (int w = 0; w < NW; w++) begin
                ref_valid[s][w] = 0; ref_dirty[s][w] = 0; ref_tag[s][w] = '0;
                ref_ord[s].push_back(w);
            end
    end

    task automatic ref_access(input logic [AW-1:0] a, input bit we, output bit hit, output int way,
                              output bit wb, output logic [AW-1:0] wb_addr, output logic [NW*LW-1:0] lru);
        int s;
        logic [TW-1:0] t;
        s = int'(a[IW-1:0]);
        t = a[AW-1:IW];
        hit = 0; way = -1; wb = 0; wb_addr = '0;
        for (int w = 0; w < NW; w++)
            if (!hit && ref_valid[s][w] && ref_tag[s][w] == t) begin hit = 1; way = w; end
        if (!hit) begin
            for (int w = 0; w < NW; w++) if (way < 0 && !ref_valid[s][w]) way = w;
            if (way < 0) way = ref_ord[s][ref_ord[s].size()-1];
            if (ref_valid[s][way] && ref_dirty[s][way]) begin
                wb = 1; wb_addr = {ref_tag[s][way], a[IW-1:0]};
            end
            ref_valid[s][way] = 1; ref_tag[s][way] = t; ref_dirty[s][way] = we;
        end else if (we) ref_dirty[s][way] = 1;
        for (int i = 0; i < ref_ord[s].size(); i++)
            if (ref_ord[s][i] == way) begin ref_ord[s].delete(i); break; end
        ref_ord[s].push_front(way);
        lru = '0;
        for (int i = 0; i < NW; i++) lru[ref_ord[s][i]*LW +: LW] = LW'(i);
    endtask

    // ---------------- checking ----------------
    int n_cmp = 0, n_bad = 0, exp_hits = 0, exp_misses = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        bit            timeout, hit, wb_seen, fill_seen, order_bad, unstable, stray;
        int            lat;
        logic [AW-1:0] wb_addr, fill_addr;
        logic [NW-1:0] wr_mask, wr_mod, clr_mask, lk_mod, upd_modwr;
    } obs_t;

    // Issue one request, serve memory with 'dly' wait cycles per transaction
    task automatic run_req(input logic [AW-1:0] a, input bit we, input int dly, output obs_t o);
        int cyc, hold, wcnt;
        bit done, prev_req, prev_we;
        logic [AW-1:0] prev_addr;
        o = '{default: 0};
        cyc = 0; hold = 0; wcnt = 0; done = 0; prev_req = 0; prev_we = 0; prev_addr = '0;
        @(negedge clk);
        while (!req_ready && wcnt < 50) begin @(negedge clk); wcnt++; end
        if (!req_ready) begin o.timeout = 1; return; end
        req_valid = 1'b1; req_addr = a; req_we = we;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = AW'($urandom);
        while (!done && cyc < 200) begin
            @(negedge clk); cyc++;
            if (mem_req) begin
                if (prev_req && mem_we == prev_we && mem_addr != prev_addr) o.unstable = 1;
                if (mem_we && !o.wb_seen) begin
                    o.wb_seen = 1; o.wb_addr = mem_addr;
                    if (o.fill_seen) o.order_bad = 1;
                end
                if (!mem_we && !o.fill_seen) begin o.fill_seen = 1; o.fill_addr = mem_addr; end
                if (!prev_req || mem_we != prev_we) hold = 0; else hold++;
                mem_ack = (hold >= dly);
            end else mem_ack = 1'b0;
            prev_req = mem_req; prev_we = mem_we; prev_addr = mem_addr;
            #1;
            if (cyc == 1) o.lk_mod = ch_mod_in;
            o.wr_mask |= ch_wr;
            if (ch_wr != 0) o.wr_mod |= ch_mod_in;
            if (ch_wr != 0 && !(mem_req && !mem_we && mem_ack)) o.stray = 1;
            if (resp_valid) begin
                o.hit = resp_hit; o.lat = cyc; o.clr_mask = ch_lru_clr;
                o.upd_modwr = ch_mod_in | ch_wr; done = 1;
            end else begin
                if ((ch_age | ch_lru_clr) != 0) o.stray = 1;
                if (cyc != 1 && ch_wr == 0 && ch_mod_in != 0) o.stray = 1;
            end
        end
        mem_ack = 1'b0;
        if (!done) o.timeout = 1;
    endtask

    task automatic check_txn(input string nm, input obs_t o, input logic [AW-1:0] a, input bit we,
                             input int dly, input bit e_hit, input int e_way, input bit e_wb,
                             input logic [AW-1:0] e_wb_addr, input logic [NW*LW-1:0] e_lru);
        int e_lat, s;
        logic [NW*LW-1:0] got;
        logic [NW-1:0] onehot;
        onehot = NW'(1) << e_way;
        e_lat = e_hit ? 2 : (3 + dly + (e_wb ? 1 + dly : 0));
        chk({nm, " timeout"}, 64'(o.timeout), 0);
        chk({nm, " resp_hit"}, 64'(o.hit), 64'(e_hit));
        chk({nm, " latency"}, 64'(o.lat), 64'(e_lat));
        chk({nm, " wb_seen"}, 64'(o.wb_seen), 64'(e_wb));
        if (e_wb) chk({nm, " wb_addr"}, 64'(o.wb_addr), 64'(e_wb_addr));
        chk({nm, " fill_seen"}, 64'(o.fill_seen), 64'(!e_hit));
        if (!e_hit) chk({nm, " fill_addr"}, 64'(o.fill_addr), 64'(a));
        chk({nm, " ch_wr"}, 64'(o.wr_mask), e_hit ? 64'(0) : 64'(onehot));
        chk({nm, " fill_mod_in"}, 64'(o.wr_mod), (e_hit || !we) ? 64'(0) : 64'(onehot));
        chk({nm, " lookup_mod_in"}, 64'(o.lk_mod), (e_hit && we) ? 64'(onehot) : 64'(0));
        chk({nm, " lru_clr"}, 64'(o.clr_mask), 64'(onehot));
        chk({nm, " update_mod_wr"}, 64'(o.upd_modwr), 0);
        chk({nm, " protocol"}, 64'({o.stray, o.unstable, o.order_bad}), 0);
        @(posedge clk); #1;
        s = int'(a[IW-1:0]);
        for (int w = 0; w < NW; w++) got[w*LW +: LW] = m_lru[s][w];
        chk({nm, " lru"}, 64'(got), 64'(e_lru));
        if (e_hit) exp_hits++; else exp_misses++;
    endtask

    typedef struct {
        logic [AW-1:0]    addr;
        bit               we;
        int               dly;
        bit               hit;
        int               way;
        bit               wb;
        logic [AW-1:0]    wb_addr;
        logic [NW*LW-1:0] lru;   // {way3, way2, way1, way0}
    } vec_t;

    vec_t vt[9];

    initial begin : main
        obs_t o;
        bit r_hit_e, r_wb_e;
        int r_way_e, wcnt, dly;
        logic [AW-1:0] r_wba_e, a;
        logic [NW*LW-1:0] r_lru_e;
        bit we;

        vt[0] = '{12'h0A3, 1'b0, 3, 1'b0, 0, 1'b0, 12'h000, 12'h688};
        vt[1] = '{12'h1B3, 1'b0, 0, 1'b0, 1, 1'b0, 12'h000, 12'h681};
        vt[2] = '{12'h0A3, 1'b0, 1, 1'b1, 0, 1'b0, 12'h000, 12'h688};
        vt[3] = '{12'h0A3, 1'b1, 0, 1'b1, 0, 1'b0, 12'h000, 12'h688};
        vt[4] = '{12'h2C3, 1'b0, 0, 1'b0, 2, 1'b0, 12'h000, 12'h611};
        vt[5] = '{12'h3D3, 1'b0, 2, 1'b0, 3, 1'b0, 12'h000, 12'h05A};
        vt[6] = '{12'h1B3, 1'b1, 0, 1'b1, 1, 1'b0, 12'h000, 12'h283};
        vt[7] = '{12'hF03, 1'b0, 2, 1'b0, 0, 1'b1, 12'h0A3, 12'h4C8};
        vt[8] = '{12'h555, 1'b1, 1, 1'b0, 0, 1'b0, 12'h000, 12'h688};

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset req_ready", 64'(req_ready), 0);
        chk("reset resp", 64'({resp_valid, resp_hit}), 0);
        chk("reset mem", 64'({mem_req, mem_we, mem_addr}), 0);
        chk("reset strobes", 64'({ch_wr, ch_mod_in, ch_age, ch_lru_clr}), 0);
        chk("reset index/tag", 64'({ch_index, ch_tag_in}), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready after reset", 64'(req_ready), 1);

        // Directed table
        for (int i = 0; i < 9; i++) begin
            ref_access(vt[i].addr, vt[i].we, r_hit_e, r_way_e, r_wb_e, r_wba_e, r_lru_e);
            run_req(vt[i].addr, vt[i].we, vt[i].dly, o);
            check_txn($sformatf("vec%0d", i), o, vt[i].addr, vt[i].we, vt[i].dly,
                      vt[i].hit, vt[i].way, vt[i].wb, vt[i].wb_addr, vt[i].lru);
        end

        // Randomized traffic against the recency-queue model
        for (int i = 0; i < 120; i++) begin
            a   = {TW'($urandom_range(0, 6)), IW'($urandom_range(0, 3))};
            we  = 1'($urandom_range(0, 1));
            dly = $urandom_range(0, 3);
            ref_access(a, we, r_hit_e, r_way_e, r_wb_e, r_wba_e, r_lru_e);
            run_req(a, we, dly, o);
            check_txn($sformatf("rnd%0d", i), o, a, we, dly, r_hit_e, r_way_e, r_wb_e, r_wba_e, r_lru_e);
        end

`ifdef CACHE_CTRL_STATS_EN
        chk("hit_cnt", 64'(hit_cnt), 64'(exp_hits));
        chk("miss_cnt", 64'(miss_cnt), 64'(exp_misses));
`endif

        // Reset in the middle of a fill: request abandoned, no write
        @(negedge clk);
        req_valid = 1'b1; req_addr = 12'h7A6; req_we = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        wcnt = 0;
        while (!(mem_req && !mem_we) && wcnt < 20) begin @(negedge clk); wcnt++; end
        chk("fill reached", 64'({mem_req, mem_we}), 64'(2'b10));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid-reset mem_req", 64'(mem_req), 0);
        chk("mid-reset ready/resp", 64'({req_ready, resp_valid}), 0);
        @(posedge clk); #1;
        chk("mid-reset no write", 64'({m_valid[6][0], ch_wr}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready after mid-reset", 64'(req_ready), 1);
`ifdef CACHE_CTRL_STATS_EN
        chk("counters after reset", 64'({hit_cnt, miss_cnt}), 0);
`endif
        ref_access(12'h7A6, 1'b0, r_hit_e, r_way_e, r_wb_e, r_wba_e, r_lru_e);
        run_req(12'h7A6, 1'b0, 1, o);
        check_txn("post-reset", o, 12'h7A6, 1'b0, 1, r_hit_e, r_way_e, r_wb_e, r_wba_e, r_lru_e);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule

`default_nettype wire
